// File: rtl/mem_access_unit_pkg.sv
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Size codes and alignment helpers for the MEM-stage load/store
//               engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_unit_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    // The unused code 2'b11 behaves as a full word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? MEM_WORD : size;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            MEM_HALF: return off[0];
            MEM_WORD: return (off != 2'b00);
            default:  return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_if.sv
// ============================================================================
// Module      : mem_access_unit_if
// Description : Pipeline request bus plus word-only data memory port of the
//               MEM-stage load/store engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_access_unit_if #(
    parameter int DM_AW = 10
);
    logic             req;
    logic             we;
    logic [1:0]       size;
    logic             uns;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic             stall;
    logic             rvalid;
    logic [31:0]      rdata;
    logic             misalign;
    logic [DM_AW-1:0] dm_addr;
    logic             dm_we;
    logic [31:0]      dm_wdata;
    logic [31:0]      dm_rdata;

    modport master (
        output req, we, size, uns, addr, wdata, dm_rdata,
        input  stall, rvalid, rdata, misalign, dm_addr, dm_we, dm_wdata
    );

    modport slave (
        input  req, we, size, uns, addr, wdata, dm_rdata,
        output stall, rvalid, rdata, misalign, dm_addr, dm_we, dm_wdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational lane extract/extend for loads and read-modify-
//               write merge for sub-word stores.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wdata,
    output logic [31:0] ext_rdata,
    output logic [31:0] merged_wdata
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v       = word[{off, 3'b000} +: 8];
        half_v       = off[1] ? word[31:16] : word[15:0];
        ext_rdata    = word;
        merged_wdata = word;
        case (size)
            MEM_BYTE: begin
                ext_rdata                        = {{24{~uns & byte_v[7]}}, byte_v};
                merged_wdata[{off, 3'b000} +: 8] = wdata[7:0];
            end
            MEM_HALF: begin
                ext_rdata = {{16{~uns & half_v[15]}}, half_v};
                if (off[1]) begin
                    merged_wdata[31:16] = wdata[15:0];
                end else begin
                    merged_wdata[15:0] = wdata[15:0];
                end
            end
            default: begin
                ext_rdata    = word;
                merged_wdata = wdata;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage load/store engine over a word-only, 1-cycle sync
//               read data memory; sub-word stores use read-modify-write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DM_AW = 10
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mem_access_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LD_WAIT  = 2'd1,
        S_ST_MERGE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] wdata_q, wdata_d;

    logic [1:0]  size_n;
    logic [31:0] ext_rdata;
    logic [31:0] merged_wdata;
    logic        unused_addr;

    assign size_n      = norm_size(bus.size);
    assign unused_addr = ^{bus.addr[31:DM_AW+2]};

    mem_lane_align u_lane_align (
        .word         (bus.dm_rdata),
        .off          (off_q),
        .size         (size_q),
        .uns          (uns_q),
        .wdata        (wdata_q),
        .ext_rdata    (ext_rdata),
        .merged_wdata (merged_wdata)
    );

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        bus.stall    = 1'b0;
        bus.rvalid   = 1'b0;
        bus.misalign = 1'b0;
        bus.dm_we    = 1'b0;
        bus.rdata    = 32'd0;
        bus.dm_wdata = 32'd0;
        bus.dm_addr  = bus.addr[DM_AW+1:2];
        // Outputs are held quiet under reset so an in-flight RMW write is dropped.
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req) begin
                        if (is_misaligned(size_n, bus.addr[1:0])) begin
                            bus.misalign = 1'b1;
                        end else if (bus.we && (size_n == MEM_WORD)) begin
                            bus.dm_we    = 1'b1;
                            bus.dm_wdata = bus.wdata;
                        end else begin
                            bus.stall = 1'b1;
                            size_d    = size_n;
                            uns_d     = bus.uns;
                            off_d     = bus.addr[1:0];
                            wdata_d   = bus.wdata;
                            state_d   = bus.we ? S_ST_MERGE : S_LD_WAIT;
                        end
                    end
                end
                S_LD_WAIT: begin
                    bus.rvalid = 1'b1;
                    bus.rdata  = ext_rdata;
                    state_d    = S_IDLE;
                end
                S_ST_MERGE: begin
                    bus.dm_we    = 1'b1;
                    bus.dm_wdata = merged_wdata;
                    state_d      = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            size_q  <= MEM_BYTE;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit against a word-array
//               reference model of memory and load/store semantics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    localparam int DM_AW = 10;
    localparam int NWORDS = 64;

    logic clk;
    logic rst;

    mem_access_unit_if #(.DM_AW(DM_AW)) bus ();

    mem_access_unit #(.DM_AW(DM_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: sync read, word writes, plus a bench-only preload port.
    logic [31:0] mem [0:(1<<DM_AW)-1];
    logic        pl_en;
    int          pl_idx;
    logic [31:0] pl_val;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end else if (bus.dm_we) begin
            mem[bus.dm_addr] <= bus.dm_wdata;
        end
        bus.dm_rdata <= mem[bus.dm_addr];
    end

    logic [31:0] ref_mem [0:(1<<DM_AW)-1];
    int          n_checks;
    int          n_fail;
    logic [31:0] obs_rdata;
    logic [31:0] obs_wdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = val;
        @(negedge clk);
        pl_en  = 1'b0;
        ref_mem[idx] = val;
    endtask

    task automatic idle_bus();
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.size  = 2'b00;
        bus.uns   = 1'b0;
        bus.addr  = 32'd0;
        bus.wdata = 32'd0;
    endtask

    // One access end to end; expectations come from plain arithmetic on ref_mem.
    task automatic access(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd);
        int          szc;
        int          widx;
        int          sh;
        logic        mis;
        logic [31:0] old;
        logic [31:0] expv;
        logic [31:0] mask;
        szc  = (sz == 2'b11) ? 2 : int'(sz);
        mis  = (szc == 1 && (a % 2) != 0) || (szc == 2 && (a % 4) != 0);
        widx = int'(a[11:2]);
        old  = ref_mem[widx];
        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.size = sz; bus.uns = u; bus.addr = a; bus.wdata = wd;
        #1;
        check_eq("dm_addr", 32'(bus.dm_addr), 32'(widx));
        if (mis) begin
            check_eq("mis_flag", 32'(bus.misalign), 32'd1);
            check_eq("mis_stall", 32'(bus.stall), 32'd0);
            check_eq("mis_we", 32'(bus.dm_we), 32'd0);
        end else if (w && szc == 2) begin
            check_eq("sw_stall", 32'(bus.stall), 32'd0);
            check_eq("sw_we", 32'(bus.dm_we), 32'd1);
            check_eq("sw_wdata", bus.dm_wdata, wd);
            obs_wdata = bus.dm_wdata;
            ref_mem[widx] = wd;
        end else begin
            check_eq("c1_stall", 32'(bus.stall), 32'd1);
            check_eq("c1_we", 32'(bus.dm_we), 32'd0);
            check_eq("c1_mis", 32'(bus.misalign), 32'd0);
            @(negedge clk);
            #1;
            check_eq("c2_stall", 32'(bus.stall), 32'd0);
            if (!w) begin
                if (szc == 0) begin
                    expv = (old >> (8 * (a % 4))) & 32'hFF;
                    if (!u && expv[7]) expv = expv | 32'hFFFFFF00;
                end else if (szc == 1) begin
                    expv = (old >> (16 * ((a / 2) % 2))) & 32'hFFFF;
                    if (!u && expv[15]) expv = expv | 32'hFFFF0000;
                end else begin
                    expv = old;
                end
                check_eq("ld_rvalid", 32'(bus.rvalid), 32'd1);
                check_eq("ld_rdata", bus.rdata, expv);
                obs_rdata = bus.rdata;
            end else begin
                sh   = (szc == 0) ? 8 * (a % 4) : 16 * ((a / 2) % 2);
                mask = ((szc == 0) ? 32'hFF : 32'hFFFF) << sh;
                expv = (old & ~mask) | ((wd << sh) & mask);
                check_eq("rmw_we", 32'(bus.dm_we), 32'd1);
                check_eq("rmw_wdata", bus.dm_wdata, expv);
                obs_wdata = bus.dm_wdata;
                ref_mem[widx] = expv;
            end
        end
        @(negedge clk);
        idle_bus();
        #1;
        check_eq("gap_quiet", {29'd0, bus.rvalid, bus.dm_we, bus.stall}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        pl_en    = 1'b0;
        pl_idx   = 0;
        pl_val   = 32'd0;
        idle_bus();
        rst = 1'b1;
        for (int i = 0; i < NWORDS; i++) begin
            preload(i, $urandom);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_outputs", {28'd0, bus.stall, bus.rvalid, bus.misalign, bus.dm_we}, 32'd0);
        check_eq("rst_rdata", bus.rdata, 32'd0);

        // Directed vectors
        preload(4, 32'h8899AABB);
        access(1'b0, 2'b00, 1'b0, 32'h13, 32'd0);
        check_eq("t1_lb", obs_rdata, 32'hFFFFFF88);
        access(1'b0, 2'b01, 1'b1, 32'h10, 32'd0);
        check_eq("t2_lhu", obs_rdata, 32'h0000AABB);
        access(1'b0, 2'b01, 1'b0, 32'h12, 32'd0);
        check_eq("t2_lh", obs_rdata, 32'hFFFF8899);
        preload(4, 32'h11223344);
        access(1'b1, 2'b00, 1'b0, 32'h11, 32'hDEADBEEF);
        check_eq("t3_sb", obs_wdata, 32'h1122EF44);
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
        check_eq("t3_rb", obs_rdata, 32'h1122EF44);
        access(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEBABE);
        access(1'b0, 2'b10, 1'b0, 32'h20, 32'd0);
        check_eq("t4_lw", obs_rdata, 32'hCAFEBABE);
        access(1'b0, 2'b10, 1'b0, 32'h22, 32'd0);
        access(1'b1, 2'b01, 1'b0, 32'h31, 32'h12345678);
        access(1'b0, 2'b11, 1'b0, 32'h24, 32'd0);
        access(1'b0, 2'b00, 1'b1, 32'h27, 32'd0);

        // Reset during the merge cycle drops the write
        preload(12, 32'h55667788);
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b01; bus.uns = 1'b0;
        bus.addr = 32'h30; bus.wdata = 32'hA5A5A5A5;
        #1;
        check_eq("t6_stall", 32'(bus.stall), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("t6_we_drop", 32'(bus.dm_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_bus();
        #1;
        check_eq("t6_idle", {29'd0, bus.stall, bus.rvalid, bus.dm_we}, 32'd0);
        access(1'b0, 2'b10, 1'b0, 32'h30, 32'd0);
        check_eq("t6_unchanged", obs_rdata, 32'h55667788);

        // Randomized traffic over a small address window
        for (int k = 0; k < 300; k++) begin
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 4 * NWORDS - 1)), $urandom);
        end

        for (int i = 0; i < NWORDS; i++) begin
            check_eq("mem_final", mem[i], ref_mem[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
